// File: rtl/audio_i2s_serializer_pkg.sv
// Shared constants and types for the I2S sample serializer.
// The frame layout is fixed: two 16-bit slots per frame, silence on underflow.
package audio_i2s_serializer_pkg;

    localparam int I2S_SLOTS   = 32;
    localparam int SAMPLE_BITS = 16;

    localparam logic [SAMPLE_BITS-1:0] SILENCE = 16'h0000;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/audio_i2s_serializer_if.sv
// Sample stream handshake between the synthesiser (master) and the serializer (slave).
// A word moves on any cycle where SampleValid and SampleReady are both high.
interface audio_i2s_serializer_if;
    import audio_i2s_serializer_pkg::*;

    sample_t SampleIn;
    logic    SampleValid;
    logic    SampleReady;

    modport master (
        output SampleIn,
        output SampleValid,
        input  SampleReady
    );

    modport slave (
        input  SampleIn,
        input  SampleValid,
        output SampleReady
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Sample buffer: circular FIFO with registered occupancy count; dout shows the head combinationally.
// Latency: one cycle push-to-visible; backpressure: pushes while full are dropped, pops while empty are ignored.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             nStart,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Both flags come from the registered count, so a same-cycle pop never frees room for a push.
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clock or negedge nStart) begin
        if (!nStart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_serializer.sv
// I2S serializer: buffers mono samples and sends each on both slots of a frame, MSB first, one-BCLK delay.
// Latency: a sample reaches DACDAT at the next frame start (<=1 frame); backpressure: SampleReady low while the FIFO is full.
module audio_i2s_serializer
    import audio_i2s_serializer_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int BITS       = SAMPLE_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         Clock,
    input  logic                         nStart,
    audio_i2s_serializer_if.slave        smp,
    output logic                         BCLK,
    output logic                         LRCK,
    output logic                         DACDAT,
    output logic                         Underflow
);

    // Slot count scales with the sample width: one slot per bit, two channels.
    localparam int SLOTS = I2S_SLOTS * BITS / SAMPLE_BITS;
    localparam int SW    = $clog2(SLOTS);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int IW    = $clog2(BITS);

    logic [DW-1:0]   div_cnt;
    logic [SW-1:0]   slot;
    logic [SW-1:0]   slot_nxt;
    logic [BITS-1:0] cur_word;
    logic [BITS-1:0] word_nxt;
    logic [IW-1:0]   bit_idx;
    logic [BITS-1:0] fifo_dout;
    logic            fifo_empty;
    logic            fifo_full;
    logic            div_wrap;
    logic            fall_tick;
    logic            pop;

    assign div_wrap  = (div_cnt == DW'(CLK_DIV - 1));
    assign fall_tick = div_wrap && BCLK;
    assign slot_nxt  = slot + 1'b1;
    assign pop       = fall_tick && (slot == '0);

    assign smp.SampleReady = !fifo_full;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BITS)
    ) u_fifo (
        .Clock (Clock),
        .nStart(nStart),
        .push  (smp.SampleValid),
        .din   (smp.SampleIn),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // The finishing frame's word is still current at slot 0, so its LSB comes straight from it.
    always_comb begin
        word_nxt = cur_word;
        if (pop) begin
            word_nxt = fifo_empty ? SILENCE : fifo_dout;
        end
        bit_idx = '0;
        if (slot_nxt == '0) begin
            bit_idx = '0;
        end else if (slot_nxt <= SW'(BITS)) begin
            bit_idx = IW'(BITS - int'(slot_nxt));
        end else begin
            bit_idx = IW'(2 * BITS - int'(slot_nxt));
        end
    end

    always_ff @(posedge Clock or negedge nStart) begin
        if (!nStart) begin
            div_cnt   <= '0;
            slot      <= '0;
            cur_word  <= '0;
            BCLK      <= 1'b0;
            LRCK      <= 1'b0;
            DACDAT    <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Underflow <= 1'b0;
            if (div_wrap) begin
                div_cnt <= '0;
                BCLK    <= !BCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_tick) begin
                slot     <= slot_nxt;
                LRCK     <= slot_nxt[SW-1];
                cur_word <= word_nxt;
                DACDAT   <= word_nxt[bit_idx];
                if (pop) begin
                    Underflow <= fifo_empty;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Self-checking bench: cycle-level reference model built from frame arithmetic, plus frame-capture vectors.
module tb_audio_i2s_serializer;

    localparam int CD    = 8;
    localparam int SLOTS = 32;
    localparam int DEPTH = 4;

    logic Clock = 1'b0;
    logic nStart;
    logic BCLK, LRCK, DACDAT, Underflow;

    audio_i2s_serializer_if sif ();

    audio_i2s_serializer #(
        .CLK_DIV   (CD),
        .BITS      (16),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clock    (Clock),
        .nStart   (nStart),
        .smp      (sif),
        .BCLK     (BCLK),
        .LRCK     (LRCK),
        .DACDAT   (DACDAT),
        .Underflow(Underflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] sample;
        logic [31:0] exp_dat;
        logic [31:0] exp_lr;
    } vec_t;

    vec_t        tbl [5];
    int          vectors = 0;
    int          miscompares = 0;
    int          p = 0;
    logic [15:0] q [$];
    logic [15:0] cur = '0;
    bit          pop_evt = 0;
    bit          uf_exp = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: clocks since reset release give BCLK phase and slot; frame starts pop the sample queue.
    task automatic step();
        logic [15:0] sh;
        int          s;
        bit          ready_pre;
        logic [4:0]  got;
        logic [4:0]  exp;
        @(posedge Clock);
        pop_evt = 0;
        uf_exp  = 0;
        if (!nStart) begin
            p = 0;
            q.delete();
            cur = '0;
        end else begin
            p++;
            ready_pre = (q.size() < DEPTH);
            if (p % (2 * CD) == 0 && (p / (2 * CD)) % SLOTS == 1) begin
                pop_evt = 1;
                uf_exp  = (q.size() == 0);
                cur     = uf_exp ? 16'h0000 : q.pop_front();
            end
            if (sif.SampleValid && ready_pre) q.push_back(sif.SampleIn);
        end
        #1;
        if (!nStart) begin
            exp = 5'b00001;
        end else begin
            s = (p / (2 * CD)) % SLOTS;
            if (s == 0)       sh = cur;
            else if (s <= 16) sh = cur >> (16 - s);
            else              sh = cur >> (32 - s);
            exp = {((p / CD) % 2) == 1, s >= 16, sh[0], uf_exp, q.size() < DEPTH};
        end
        got = {BCLK, LRCK, DACDAT, Underflow, sif.SampleReady};
        check($sformatf("cycle p=%0d {bclk,lrck,dat,uf,rdy}", p), 32'(got), 32'(exp));
    endtask

    task automatic wait_pop(input bit want_word, output bit ok);
        ok = 0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            step();
            if (pop_evt && (!want_word || !uf_exp)) ok = 1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pop timeout: got no frame start, required one within 1500 cycles");
        end
    endtask

    // Collects DACDAT/LRCK from the current fall tick onward, one bit per BCLK period.
    task automatic capture(input int nbits, output logic [31:0] dat_bits, output logic [31:0] lr_bits);
        dat_bits = {31'b0, DACDAT};
        lr_bits  = {31'b0, LRCK};
        for (int n = 1; n < nbits; n++) begin
            int guard;
            guard = 0;
            step();
            while (p % (2 * CD) != 0 && guard < 100) begin
                step();
                guard++;
            end
            dat_bits = {dat_bits[30:0], DACDAT};
            lr_bits  = {lr_bits[30:0], LRCK};
        end
    endtask

    task automatic push_one(input logic [15:0] v);
        sif.SampleValid = 1'b1;
        sif.SampleIn    = v;
        step();
        sif.SampleValid = 1'b0;
    endtask

    initial begin
        bit          ok;
        int          accepted;
        int          pulses;
        logic [31:0] db, lb;

        tbl[0] = '{16'hA5C3, 32'hA5C3_A5C3, 32'h0001_FFFE};
        tbl[1] = '{16'h8000, 32'h8000_8000, 32'h0001_FFFE};
        tbl[2] = '{16'h7FFF, 32'h7FFF_7FFF, 32'h0001_FFFE};
        tbl[3] = '{16'h0001, 32'h0001_0001, 32'h0001_FFFE};
        tbl[4] = '{16'hFFFF, 32'hFFFF_FFFF, 32'h0001_FFFE};

        nStart          = 1'b0;
        sif.SampleValid = 1'b0;
        sif.SampleIn    = '0;
        repeat (5) step();
        nStart = 1'b1;

        // Single samples into an empty FIFO: full 32-slot frame including next slot 0.
        foreach (tbl[i]) begin
            wait_pop(0, ok);
            push_one(tbl[i].sample);
            wait_pop(1, ok);
            if (ok) begin
                capture(32, db, lb);
                check($sformatf("frame_dat[%0d]", i), db, tbl[i].exp_dat);
                check($sformatf("frame_lr[%0d]", i), lb, tbl[i].exp_lr);
            end
        end

        // Backpressure: six offers right after a frame start, only four fit.
        wait_pop(0, ok);
        accepted = 0;
        for (int k = 1; k <= 6; k++) begin
            sif.SampleValid = 1'b1;
            sif.SampleIn    = 16'(k);
            if (sif.SampleReady) accepted++;
            step();
        end
        sif.SampleValid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_ready_low", 32'(sif.SampleReady), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            wait_pop(1, ok);
            if (ok) begin
                capture(16, db, lb);
                check($sformatf("bp_order[%0d]", k), {16'h0, db[15:0]}, 32'(k));
            end
        end
        wait_pop(0, ok);
        check("bp_dropped_underflow", 32'(Underflow), 32'd1);

        // Two idle frames: one Underflow pulse each.
        pulses = 0;
        for (int i = 0; i < 2 * SLOTS * 2 * CD; i++) begin
            step();
            if (Underflow) pulses++;
        end
        check("idle_uf_pulses", 32'(pulses), 32'd2);

        // Extremes back to back.
        wait_pop(0, ok);
        push_one(16'h8000);
        push_one(16'h7FFF);
        wait_pop(1, ok);
        if (ok) begin
            capture(16, db, lb);
            check("extreme_neg_left", {16'h0, db[15:0]}, 32'h8000);
        end
        wait_pop(1, ok);
        if (ok) begin
            capture(16, db, lb);
            check("extreme_pos_left", {16'h0, db[15:0]}, 32'h7FFF);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sif.SampleValid = ($urandom % 4) == 0;
            sif.SampleIn    = 16'($urandom);
            step();
        end
        sif.SampleValid = 1'b0;
        for (int i = 0; i < 5; i++) wait_pop(0, ok);

        // Mid-frame reset with three samples queued.
        push_one(16'h1111);
        push_one(16'h2222);
        push_one(16'h3333);
        for (int i = 0; i < 1000 && ((p / (2 * CD)) % SLOTS) != 9; i++) step();
        check("reached_slot9", 32'((p / (2 * CD)) % SLOTS), 32'd9);
        step();
        step();
        nStart = 1'b0;
        #1;
        check("async_reset_outputs", {27'h0, BCLK, LRCK, DACDAT, Underflow, sif.SampleReady}, 32'h1);
        repeat (3) step();
        nStart = 1'b1;
        wait_pop(0, ok);
        check("post_reset_underflow", 32'(Underflow), 32'd1);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
